// File: rtl/pixel_distributor_if.sv
// Coordinate-offer link between the pixel distributor and its bank of engines:
// shared x/y coordinate, one valid bit and one ready bit per engine.
interface pixel_distributor_if #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10
);
  logic [NUM_ENGINES-1:0]      pixel_valid;
  logic [NUM_ENGINES-1:0]      engine_ready;
  logic [PIXEL_DATA_WIDTH-1:0] x0_;
  logic [PIXEL_DATA_WIDTH-1:0] y0_;

  modport master (
    output pixel_valid,
    output x0_,
    output y0_,
    input  engine_ready
  );

  modport slave (
    input  pixel_valid,
    input  x0_,
    input  y0_,
    output engine_ready
  );
endinterface

// File: rtl/pixel_distributor.sv
// Raster-scans one frame of pixel coordinates and hands each one to a single
// engine, chosen round-robin among the engines that are ready.
module pixel_distributor #(
  parameter int NUM_ENGINES      = 4,
  parameter int PIXEL_DATA_WIDTH = 10,
  parameter int SCREEN_WIDTH     = 640,
  parameter int SCREEN_HEIGHT    = 480
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  pixel_distributor_if.master        eng,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e                      state_q;
  logic [NUM_ENGINES-1:0]      valid_q;
  logic [PIXEL_DATA_WIDTH-1:0] x_q;
  logic [PIXEL_DATA_WIDTH-1:0] y_q;
  logic [PTR_W-1:0]            rr_q;
  logic                        busy_q;
  logic                        done_q;

  logic                        xfer_s;
  logic                        last_s;
  logic                        slot_free_s;
  logic [PTR_W-1:0]            cur_idx_s;
  logic [PTR_W-1:0]            rr_d;
  logic [PTR_W-1:0]            base_s;
  logic                        sel_found_s;
  logic [PTR_W-1:0]            sel_idx_s;
  logic [NUM_ENGINES-1:0]      sel_onehot_s;
  logic [PIXEL_DATA_WIDTH-1:0] x_d;
  logic [PIXEL_DATA_WIDTH-1:0] y_d;
  int                          scan_idx_s;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    if (int'(v) + 1 >= NUM_ENGINES) begin
      return PTR_W'(0);
    end else begin
      return PTR_W'(int'(v) + 1);
    end
  endfunction

  // Transfer detection, granted index and the raster-order next coordinate.
  always_comb begin
    xfer_s    = |(valid_q & eng.engine_ready);
    last_s    = (x_q == PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1)) &&
                (y_q == PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1));
    slot_free_s = (valid_q == '0) || xfer_s;
    cur_idx_s = PTR_W'(0);
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (valid_q[i]) begin
        cur_idx_s = PTR_W'(i);
      end else begin
        cur_idx_s = cur_idx_s;
      end
    end
    // The pointer moves only on an accepted transfer; it names the first engine to scan.
    rr_d   = xfer_s ? wrap_inc(cur_idx_s) : rr_q;
    base_s = rr_d;
    if (x_q == PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1)) begin
      x_d = PIXEL_DATA_WIDTH'(0);
      y_d = y_q + PIXEL_DATA_WIDTH'(1);
    end else begin
      x_d = x_q + PIXEL_DATA_WIDTH'(1);
      y_d = y_q;
    end
  end

  // Round-robin scan of the ready vector starting at the pointer, wrapping once.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = PTR_W'(0);
    scan_idx_s  = 0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      scan_idx_s = (int'(base_s) + i) % NUM_ENGINES;
      if (!sel_found_s && eng.engine_ready[scan_idx_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = PTR_W'(scan_idx_s);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
    sel_onehot_s = sel_found_s ? (NUM_ENGINES'(1) << sel_idx_s) : '0;
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            valid_q <= sel_onehot_s;
            state_q <= ST_ISSUE;
          end else begin
            valid_q <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          rr_q <= rr_d;
          if (xfer_s && last_s) begin
            valid_q <= '0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else if (slot_free_s) begin
            // A stalled selection keeps the advanced coordinate and retries.
            if (xfer_s) begin
              x_q <= x_d;
              y_q <= y_d;
            end else begin
              x_q <= x_q;
              y_q <= y_q;
            end
            valid_q <= sel_onehot_s;
          end else begin
            valid_q <= valid_q;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          valid_q <= '0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign eng.pixel_valid = valid_q;
  assign eng.x0_         = x_q;
  assign eng.y0_         = y_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_pixel_distributor.sv
// Directed bench: a single-engine 4x3 frame and a four-engine 8x2 frame
// covering rotation, backpressure, skipping, reset and start-while-busy.
module tb_pixel_distributor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_a, start_a, busy_a, done_a;
  logic reset_b, start_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  pixel_distributor_if #(.NUM_ENGINES(1), .PIXEL_DATA_WIDTH(10)) ifa ();
  pixel_distributor_if #(.NUM_ENGINES(4), .PIXEL_DATA_WIDTH(10)) ifb ();

  pixel_distributor #(
    .NUM_ENGINES(1), .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(3)
  ) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a), .eng(ifa),
    .busy(busy_a), .frame_done(done_a)
  );

  pixel_distributor #(
    .NUM_ENGINES(4), .PIXEL_DATA_WIDTH(10), .SCREEN_WIDTH(8), .SCREEN_HEIGHT(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .eng(ifb),
    .busy(busy_b), .frame_done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [3:0] v, input int x, input int y);
    chk({tag, "_valid"}, 32'(ifb.pixel_valid), 32'(v));
    chk({tag, "_x"}, 32'(ifb.x0_), 32'(x));
    chk({tag, "_y"}, 32'(ifb.y0_), 32'(y));
  endtask

  initial begin
    logic [3:0] rot_v [6];
    logic       seen;
    rot_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    reset_a = 1'b1; start_a = 1'b0; ifa.engine_ready = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; ifb.engine_ready = 4'b0000;
    step();
    step();

    // Reset state of both instances
    chk("a_rst_valid", 32'(ifa.pixel_valid), 32'd0);
    chk("a_rst_busy", 32'(busy_a), 32'd0);
    chk("a_rst_done", 32'(done_a), 32'd0);
    chk("b_rst_valid", 32'(ifb.pixel_valid), 32'd0);
    chk("b_rst_xy", 32'({ifb.x0_, ifb.y0_}), 32'd0);
    chk("b_rst_busy", 32'(busy_b), 32'd0);

    // Single engine, 4x3 frame: one transfer per cycle in raster order
    reset_a = 1'b0; ifa.engine_ready = 1'b1; start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("a_seq_valid", 32'(ifa.pixel_valid), 32'd1);
      chk("a_seq_x", 32'(ifa.x0_), 32'(i % 4));
      chk("a_seq_y", 32'(ifa.y0_), 32'(i / 4));
      step();
    end
    chk("a_done_valid", 32'(ifa.pixel_valid), 32'd0);
    chk("a_done_pulse", 32'(done_a), 32'd1);
    chk("a_done_busy", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_idle_done", 32'(done_a), 32'd0);
    chk("a_idle_busy", 32'(busy_a), 32'd0);
    chk("a_idle_valid", 32'(ifa.pixel_valid), 32'd0);
    step();
    chk("a_idle_start_ignored", 32'(busy_a), 32'd0);

    // Four engines, all ready: rotation 0,1,2,3,0,1
    reset_b = 1'b0; ifb.engine_ready = 4'b1111; start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk_b("b_rot", rot_v[i], i, 0);
      if (i < 5) step();
    end

    // Backpressure on engine 1 holding (5,0); start while busy is ignored
    ifb.engine_ready = 4'b1101; start_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start_b = 1'b0;
      chk_b("b_hold", 4'b0010, 5, 0);
    end
    ifb.engine_ready = 4'b1111;
    step();
    chk_b("b_release", 4'b0100, 6, 0);

    // Engine 2 accepts, then only engines 0 and 3 are ready
    ifb.engine_ready = 4'b1101;
    step();
    chk_b("b_skip0", 4'b1000, 7, 0);
    ifb.engine_ready = 4'b1001;
    step();
    chk_b("b_skip1", 4'b0001, 0, 1);
    step();
    chk_b("b_skip2", 4'b1000, 1, 1);
    step();
    chk_b("b_skip3", 4'b0001, 2, 1);

    // Reset in mid-frame drops the offer
    reset_b = 1'b1;
    step();
    chk_b("b_midrst", 4'b0000, 0, 0);
    chk("b_midrst_busy", 32'(busy_b), 32'd0);
    chk("b_midrst_done", 32'(done_b), 32'd0);

    // Restart with no engine ready: no offer, coordinate held at (0,0)
    reset_b = 1'b0; ifb.engine_ready = 4'b0000; start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk_b("b_noready0", 4'b0000, 0, 0);
    chk("b_noready_busy", 32'(busy_b), 32'd1);
    step();
    chk_b("b_noready1", 4'b0000, 0, 0);
    start_b = 1'b1; ifb.engine_ready = 4'b0100;
    step();
    start_b = 1'b0;
    chk_b("b_restart0", 4'b0100, 0, 0);
    ifb.engine_ready = 4'b1111;
    step();
    chk_b("b_restart1", 4'b1000, 1, 0);

    // Run the rest of the frame, bounded
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (done_b) seen = 1'b1;
    end
    chk("b_frame_done_seen", 32'(seen), 32'd1);
    chk("b_done_busy", 32'(busy_b), 32'd1);
    chk("b_done_valid", 32'(ifb.pixel_valid), 32'd0);
    step();
    chk("b_after_busy", 32'(busy_b), 32'd0);
    chk("b_after_done", 32'(done_b), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
